// File: rtl/fault_sim_pkg.sv
// fault_sim_pkg: sequencer state encoding, index-width helpers and detection record shared by the fault-sim sequencer
package fault_sim_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INJECT  = 4'd1,
    FETCH   = 4'd2,
    APPLY   = 4'd3,
    COMPARE = 4'd4,
    REPORT  = 4'd5,
    NEXT    = 4'd6,
    REMOVE  = 4'd7,
    DONE    = 4'd8
  } fsimState_e;
  localparam int DET_ID_MAX_W = 16;
  localparam int DET_DIFF_MAX_W = 64;
  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cntW(input int n);
    return $clog2(n + 1);
  endfunction
  typedef struct packed {
    logic [DET_ID_MAX_W-1:0] fault;
    logic [DET_ID_MAX_W-1:0] vec;
    logic [DET_DIFF_MAX_W-1:0] diff;
  } detRec_t;
endpackage

// File: rtl/fault_sim_seq_det_skid.sv
// fsim_det_skid: one-entry register slice holding a detection record until the consumer accepts it
module fsim_det_skid import fault_sim_pkg::*; #(
  parameter type rec_t = detRec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  rec_t capRec,
  input  logic ready,
  output logic valid,
  output rec_t heldRec
);
  // Capture on load and keep the record stable until valid && ready
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      heldRec <= '0;
    end else if (load) begin
      valid <= 1'b1;
      heldRec <= capRec;
    end else if (valid && ready) valid <= 1'b0;
  end
endmodule

// File: rtl/fault_sim_seq.sv
// fault_sim_seq: serial fault-simulation sequencer; define FSIM_FAULT_DROP_EN to skip remaining vectors after a fault's first detection
module fault_sim_seq import fault_sim_pkg::*; #(
  parameter int VEC_W = 6,
  parameter int OUT_W = 1,
  parameter int NUM_FAULTS = 16,
  parameter int NUM_VECTORS = 16,
  parameter int SETTLE_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [idxW(NUM_VECTORS)-1:0] vec_addr,
  input  logic [VEC_W-1:0] vec_data,
  output logic [VEC_W-1:0] cut_vec,
  output logic [idxW(NUM_FAULTS)-1:0] fault_id,
  output logic fault_inj,
  input  logic [OUT_W-1:0] resp_good,
  input  logic [OUT_W-1:0] resp_faulty,
  output logic det_valid,
  input  logic det_ready,
  output logic [idxW(NUM_FAULTS)-1:0] det_fault,
  output logic [idxW(NUM_VECTORS)-1:0] det_vec,
  output logic [OUT_W-1:0] det_diff,
  output logic [cntW(NUM_FAULTS)-1:0] detected_cnt,
  output logic [cntW(NUM_FAULTS)-1:0] fault_cnt
);
  localparam int FID_W = idxW(NUM_FAULTS);
  localparam int VID_W = idxW(NUM_VECTORS);
  localparam int HOLD_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int HOLD_W = cntW(HOLD_MAX);
`ifdef FSIM_FAULT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  typedef struct packed {
    logic [FID_W-1:0] fault;
    logic [VID_W-1:0] vec;
    logic [OUT_W-1:0] diff;
  } detSlice_t;
  fsimState_e state, nextState;
  logic [FID_W-1:0] f;
  logic [VID_W-1:0] v;
  logic [HOLD_W-1:0] holdCnt;
  logic [NUM_FAULTS-1:0] detMask;
  logic [OUT_W-1:0] diff;
  logic mismatch, holdDone, lastVec, lastFault;
  detSlice_t capRec, heldRec;
  assign diff = resp_good ^ resp_faulty;
  assign mismatch = |diff;
  assign lastVec = v == VID_W'(NUM_VECTORS - 1);
  assign lastFault = f == FID_W'(NUM_FAULTS - 1);
  assign holdDone = holdCnt == ((state == APPLY) ? HOLD_W'(SETTLE_CYC - 1) : HOLD_W'(GAP_CYC - 1));
  assign busy = (state != IDLE) && (state != DONE);
  assign done = state == DONE;
  assign vec_addr = v;
  assign fault_id = f;
  assign capRec = '{fault: f, vec: v, diff: diff};
  assign det_fault = heldRec.fault;
  assign det_vec = heldRec.vec;
  assign det_diff = heldRec.diff;
  fsim_det_skid #(.rec_t(detSlice_t)) detSkid (
    .clk(clk),
    .rst(rst),
    .load(state == COMPARE && mismatch),
    .capRec(capRec),
    .ready(det_ready),
    .valid(det_valid),
    .heldRec(heldRec)
  );
  // Campaign sequencing: one fault at a time, one vector at a time
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = start ? INJECT : IDLE;
      INJECT:  nextState = FETCH;
      FETCH:   nextState = APPLY;
      APPLY:   nextState = holdDone ? COMPARE : APPLY;
      COMPARE: nextState = mismatch ? REPORT : NEXT;
      REPORT:  nextState = det_ready ? (DROP ? REMOVE : NEXT) : REPORT;
      NEXT:    nextState = lastVec ? REMOVE : FETCH;
      REMOVE:  nextState = holdDone ? (lastFault ? DONE : INJECT) : REMOVE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // State, indices, CUT drive and coverage counters; REMOVE side effects fire on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      f <= '0;
      v <= '0;
      holdCnt <= '0;
      detMask <= '0;
      fault_inj <= 1'b0;
      cut_vec <= '0;
      detected_cnt <= '0;
      fault_cnt <= '0;
    end else begin
      state <= nextState;
      holdCnt <= (nextState == state) ? holdCnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        f <= '0;
        detMask <= '0;
        detected_cnt <= '0;
        fault_cnt <= '0;
      end
      if (state == INJECT) begin
        fault_inj <= 1'b1;
        v <= '0;
      end
      if (state == APPLY && holdCnt == '0) cut_vec <= vec_data;
      if (state == COMPARE && mismatch && !detMask[f]) begin
        detMask[f] <= 1'b1;
        detected_cnt <= detected_cnt + 1'b1;
      end
      if (state == NEXT && !lastVec) v <= v + 1'b1;
      if (nextState == REMOVE && state != REMOVE) begin
        fault_inj <= 1'b0;
        cut_vec <= '0;
        fault_cnt <= fault_cnt + 1'b1;
      end
      if (state == REMOVE && holdDone && !lastFault) f <= f + 1'b1;
    end
  end
endmodule
